// File: rtl/reg_writeback_arbiter.sv
// rtl/reg_writeback_arbiter.sv - two-source writeback FIFOs serialised onto one register-bank write port
// Also reports read-after-write hazards for the two decode read addresses.

module reg_writeback_fifo #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                push,
    input  logic                pop,
    input  logic [AW-1:0]       push_rd,
    input  logic [DW-1:0]       push_data,
    output logic                full,
    output logic                not_empty,
    output logic [AW-1:0]       head_rd,
    output logic [DW-1:0]       head_data,
    output logic [DEPTH*AW-1:0] rd_flat,
    output logic [DEPTH-1:0]    occ
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == (PW+1)'(DEPTH));
    assign not_empty = (count != '0);
    // A full FIFO refuses the push even when the head is popped in the same cycle.
    assign do_push   = push && !full;
    assign do_pop    = pop && not_empty;
    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + (PW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Slot i is occupied when its distance from the read pointer is below the count.
    always_comb begin
        occ     = '0;
        rd_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i]              = ({1'b0, PW'(i) - rd_ptr} < count);
            rd_flat[i*AW +: AW] = rd_mem[i];
        end
    end
endmodule

module reg_writeback_arbiter #(
    parameter int SIZE       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [$clog2(SIZE)-1:0]  alu_rd,
    input  logic [SIZE-1:0]          alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [$clog2(SIZE)-1:0]  mem_rd,
    input  logic [SIZE-1:0]          mem_data,
    input  logic [$clog2(SIZE)-1:0]  reg1r,
    input  logic [$clog2(SIZE)-1:0]  reg2r,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic                     RegWrite,
    output logic [$clog2(SIZE)-1:0]  regW,
    output logic [SIZE-1:0]          writeData,
    output logic                     busy
);
    localparam int AW = $clog2(SIZE);

    logic                     alu_full, mem_full;
    logic                     alu_ne, mem_ne;
    logic                     alu_push, mem_push;
    logic [AW-1:0]            alu_head_rd, mem_head_rd;
    logic [SIZE-1:0]          alu_head_data, mem_head_data;
    logic [FIFO_DEPTH*AW-1:0] alu_rd_flat, mem_rd_flat;
    logic [FIFO_DEPTH-1:0]    alu_occ, mem_occ;
    logic                     grant_alu, grant_mem;
    logic                     last_mem;
    logic                     h1, h2;

    assign alu_ready = !alu_full;
    assign mem_ready = !mem_full;
    // Writes to x0 finish the handshake but are dropped here.
    assign alu_push  = alu_valid && alu_ready && (alu_rd != '0);
    assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);

    reg_writeback_fifo #(.AW(AW), .DW(SIZE), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (alu_push),
        .pop       (grant_alu),
        .push_rd   (alu_rd),
        .push_data (alu_data),
        .full      (alu_full),
        .not_empty (alu_ne),
        .head_rd   (alu_head_rd),
        .head_data (alu_head_data),
        .rd_flat   (alu_rd_flat),
        .occ       (alu_occ)
    );

    reg_writeback_fifo #(.AW(AW), .DW(SIZE), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (mem_push),
        .pop       (grant_mem),
        .push_rd   (mem_rd),
        .push_data (mem_data),
        .full      (mem_full),
        .not_empty (mem_ne),
        .head_rd   (mem_head_rd),
        .head_data (mem_head_data),
        .rd_flat   (mem_rd_flat),
        .occ       (mem_occ)
    );

    // On a tie, the source that did not win last time gets the port.
    assign grant_alu = alu_ne && (!mem_ne || last_mem);
    assign grant_mem = mem_ne && (!alu_ne || !last_mem);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RegWrite  <= 1'b0;
            regW      <= '0;
            writeData <= '0;
            last_mem  <= 1'b1;
        end else if (grant_alu) begin
            RegWrite  <= 1'b1;
            regW      <= alu_head_rd;
            writeData <= alu_head_data;
            last_mem  <= 1'b0;
        end else if (grant_mem) begin
            RegWrite  <= 1'b1;
            regW      <= mem_head_rd;
            writeData <= mem_head_data;
            last_mem  <= 1'b1;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    always_comb begin
        h1 = RegWrite && (regW == reg1r);
        h2 = RegWrite && (regW == reg2r);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_occ[i] && (alu_rd_flat[i*AW +: AW] == reg1r)) h1 = 1'b1;
            if (mem_occ[i] && (mem_rd_flat[i*AW +: AW] == reg1r)) h1 = 1'b1;
            if (alu_occ[i] && (alu_rd_flat[i*AW +: AW] == reg2r)) h2 = 1'b1;
            if (mem_occ[i] && (mem_rd_flat[i*AW +: AW] == reg2r)) h2 = 1'b1;
        end
    end

    assign hazard1 = h1 && (reg1r != '0);
    assign hazard2 = h2 && (reg2r != '0);
    assign busy    = alu_ne || mem_ne || RegWrite;
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// tb/tb_reg_writeback_arbiter.sv - directed self-checking bench for reg_writeback_arbiter

module tb_reg_writeback_arbiter;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd = '0, mem_rd = '0, reg1r = '0, reg2r = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        hazard1, hazard2, RegWrite, busy;
    logic [4:0]  regW;
    logic [31:0] writeData;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [4:0]  log_rd[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    reg_writeback_arbiter #(.SIZE(32), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .reg1r(reg1r), .reg2r(reg2r), .hazard1(hazard1), .hazard2(hazard2),
        .RegWrite(RegWrite), .regW(regW), .writeData(writeData), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (RegWrite) begin
            log_rd.push_back(regW);
            log_data.push_back(writeData);
            log_cyc.push_back(cyc);
        end
    end

    task automatic apply_reset();
        @(negedge CLK);
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
        reg1r = '0; reg2r = '0;
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        log_rd.delete(); log_data.delete(); log_cyc.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0b expected 0", RegWrite); end
        checks++; if (regW !== 5'd0) begin errors++; $display("FAIL reset_regw: got %0d expected 0", regW); end
        checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", writeData); end
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b%0b expected 11", alu_ready, mem_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %0b%0b expected 00", hazard1, hazard2); end
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(k + 1); alu_data = 32'hA0 + k;
            mem_valid = 1'b1; mem_rd = 5'(k + 20); mem_data = 32'hB0 + k;
            @(posedge CLK); @(negedge CLK);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL burst_busy: got %0b expected 1", busy); end
        RESET = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || RegWrite !== 1'b0) begin errors++; $display("FAIL async_reset: busy %0b RegWrite %0b expected 0 0", busy, RegWrite); end
        @(negedge CLK);
        RESET = 1'b1;
        log_rd.delete(); log_data.delete(); log_cyc.delete();
        repeat (3) begin
            @(negedge CLK);
            checks++; if (RegWrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: RegWrite %0b busy %0b expected 0 0", RegWrite, busy); end
        end
    endtask

    task automatic test_single();
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; reg1r = 5'd5;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b expected 1", alu_ready); end
        @(posedge CLK); @(negedge CLK);
        alu_valid = 1'b0;
        checks++; if (RegWrite !== 1'b0 || hazard1 !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_queued: RegWrite %0b hazard1 %0b busy %0b expected 0 1 1", RegWrite, hazard1, busy); end
        @(negedge CLK);
        checks++; if (RegWrite !== 1'b1 || regW !== 5'd5 || writeData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write: got %0b %0d %0h expected 1 5 deadbeef", RegWrite, regW, writeData); end
        checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL single_hazard_outstage: got %0b expected 1", hazard1); end
        @(negedge CLK);
        checks++; if (RegWrite !== 1'b0 || hazard1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_retired: RegWrite %0b hazard1 %0b busy %0b expected 0 0 0", RegWrite, hazard1, busy); end
        checks++; if (regW !== 5'd5 || writeData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold: got %0d %0h expected 5 deadbeef", regW, writeData); end
    endtask

    task automatic test_x0();
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %0b expected 1", alu_ready); end
        @(posedge CLK); @(negedge CLK);
        alu_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %0b expected 0", busy); end
        repeat (3) @(negedge CLK);
        checks++; if (log_rd.size() != 0) begin errors++; $display("FAIL x0_no_write: got %0d writes expected 0", log_rd.size()); end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_rd[8];
        logic [31:0] exp_data[8];
        int n = 0;
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            exp_rd[2*k-2] = 5'(k);      exp_data[2*k-2] = 32'hA000_0000 + k;
            exp_rd[2*k-1] = 5'(k + 10); exp_data[2*k-1] = 32'hB000_0000 + k;
        end
        for (int k = 1; k <= 4; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(k);      alu_data = 32'hA000_0000 + k;
            mem_valid = 1'b1; mem_rd = 5'(k + 10); mem_data = 32'hB000_0000 + k;
            checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL rr_ready: got %0b%0b expected 11", alu_ready, mem_ready); end
            @(posedge CLK); @(negedge CLK);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        while (busy && n < 30) begin @(negedge CLK); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_timeout: busy %0b expected 0", busy); end
        checks++; if (log_rd.size() != 8) begin errors++; $display("FAIL rr_count: got %0d expected 8", log_rd.size()); end
        if (log_rd.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (log_rd[i] !== exp_rd[i] || log_data[i] !== exp_data[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d/%0h expected %0d/%0h", i, log_rd[i], log_data[i], exp_rd[i], exp_data[i]); end
                if (i > 0) begin
                    checks++; if (log_cyc[i] != log_cyc[i-1] + 1) begin errors++; $display("FAIL rr_back_to_back[%0d]: got cycle %0d expected %0d", i, log_cyc[i], log_cyc[i-1] + 1); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int ai = 0, mi = 0, first_stall = -1, cycles = 0, ap = 0, mp = 0;
        logic a_go, m_go;
        apply_reset();
        while ((ai < 8 || mi < 8 || busy) && cycles < 100) begin
            alu_valid = (ai < 8); alu_rd = 5'(ai + 1);  alu_data = 32'hC000_0000 + ai;
            mem_valid = (mi < 8); mem_rd = 5'(mi + 16); mem_data = 32'hD000_0000 + mi;
            a_go = alu_valid && alu_ready;
            m_go = mem_valid && mem_ready;
            if (mem_valid && !mem_ready && first_stall < 0) first_stall = mi;
            @(posedge CLK);
            if (a_go) ai++;
            if (m_go) mi++;
            @(negedge CLK);
            cycles++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        checks++; if (cycles >= 100) begin errors++; $display("FAIL bp_timeout: got %0d cycles expected < 100", cycles); end
        checks++; if (first_stall != 6) begin errors++; $display("FAIL bp_first_stall: got %0d transfers expected 6", first_stall); end
        checks++; if (log_rd.size() != 16) begin errors++; $display("FAIL bp_write_count: got %0d expected 16", log_rd.size()); end
        for (int i = 0; i < log_rd.size(); i++) begin
            if (log_rd[i] < 5'd16) begin
                checks++; if (log_rd[i] !== 5'(ap + 1) || log_data[i] !== 32'hC000_0000 + ap) begin errors++; $display("FAIL bp_alu[%0d]: got %0d/%0h expected %0d/%0h", ap, log_rd[i], log_data[i], ap + 1, 32'hC000_0000 + ap); end
                ap++;
            end else begin
                checks++; if (log_rd[i] !== 5'(mp + 16) || log_data[i] !== 32'hD000_0000 + mp) begin errors++; $display("FAIL bp_mem[%0d]: got %0d/%0h expected %0d/%0h", mp, log_rd[i], log_data[i], mp + 16, 32'hD000_0000 + mp); end
                mp++;
            end
        end
    endtask

    task automatic test_hazard();
        apply_reset();
        reg1r = 5'd0; reg2r = 5'd7;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
        @(posedge CLK); @(negedge CLK);
        mem_valid = 1'b0;
        checks++; if (hazard2 !== 1'b1 || hazard1 !== 1'b0) begin errors++; $display("FAIL hz_queued: got %0b%0b expected h1=0 h2=1", hazard1, hazard2); end
        @(negedge CLK);
        checks++; if (RegWrite !== 1'b1 || regW !== 5'd7 || hazard2 !== 1'b1) begin errors++; $display("FAIL hz_write: RegWrite %0b regW %0d hazard2 %0b expected 1 7 1", RegWrite, regW, hazard2); end
        @(negedge CLK);
        checks++; if (hazard2 !== 1'b0 || hazard1 !== 1'b0) begin errors++; $display("FAIL hz_cleared: got %0b%0b expected 00", hazard1, hazard2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_x0();
        test_round_robin();
        test_backpressure();
        test_hazard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
